// File: rtl/lt1364_mux_sequencer_pkg.sv
// lt1364_seq_pkg -- shared types and constants for the LT1364 buffer mux sequencer.
//   Sequencer state encoding, output channel identifiers, round-robin pointer helper.
//   No ports (package). Configuration macro LT1364_SEQ_BLANK_EN is consumed by the top.
package lt1364_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SWITCH  = 3'd1,
    SETTLE  = 3'd2,
    STROBE  = 3'd3,
    HOLD    = 3'd4,
    RELEASE = 3'd5
  } seq_state_e;

  // Plain-vector copies of the state codes for the FSM register.
  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_SWITCH  = SWITCH;
  localparam logic [2:0] ST_SETTLE  = SETTLE;
  localparam logic [2:0] ST_STROBE  = STROBE;
  localparam logic [2:0] ST_HOLD    = HOLD;
  localparam logic [2:0] ST_RELEASE = RELEASE;

  // REQ_CH encoding: 0 routes through the OUT1 buffer, 1 through OUT2.
  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  // Next round-robin start position after serving index idx out of n.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lt1364_mux_sequencer_if.sv
// lt1364_mux_sequencer_if -- requester/front-end bundle of the mux sequencer.
//   req, req_ch        : requester level requests and target channel
//   gnt                : one-hot grant
//   mux1_sel/en        : channel-1 input mux controls
//   mux2_sel/en        : channel-2 input mux controls
//   sample/done/abort  : single-cycle status strobes
//   busy               : conversion in flight
// master = requester / front-end side, slave = sequencer.
interface lt1364_mux_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int SEL_W = 2
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  req_ch;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] mux1_sel;
  logic             mux1_en;
  logic [SEL_W-1:0] mux2_sel;
  logic             mux2_en;
  logic             sample;
  logic             done;
  logic             abort;
  logic             busy;

  modport master (
    output req, req_ch,
    input  gnt, mux1_sel, mux1_en, mux2_sel, mux2_en, sample, done, abort, busy
  );

  modport slave (
    input  req, req_ch,
    output gnt, mux1_sel, mux1_en, mux2_sel, mux2_en, sample, done, abort, busy
  );
endinterface

// File: rtl/lt1364_mux_sequencer_rr_arbiter.sv
// rr_arbiter -- combinational round-robin pick.
//   i_req   : request vector
//   i_ptr   : index with highest priority this round
//   o_gnt   : one-hot winner (first set bit at or above i_ptr, wrapping)
//   o_idx   : binary index of the winner
//   o_valid : any request present
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int SEL_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_valid
);

  logic [SEL_W-1:0] w_pos;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pos = SEL_W'((int'(i_ptr) + i) % NREQ);
      if (!o_valid && i_req[w_pos]) begin
        o_valid      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/lt1364_mux_sequencer.sv
// lt1364_mux_sequencer -- shares the two LT1364 buffer channels among NREQ requesters.
//   i_clk   : system clock, rising edge
//   i_rst_n : synchronous active-low reset
//   io_bus  : slave side of lt1364_mux_sequencer_if (requests in, grant/mux/status out)
// Optional build macro LT1364_SEQ_BLANK_EN: hold the idle channel's enable low
// from SWITCH through STROBE (crosstalk blanking).
//
// state   | meaning
// IDLE    | waiting for a request; registers the round-robin winner and its mux select
// SWITCH  | enable the chosen channel's mux, load settle count
// SETTLE  | wait for the op-amp to settle; granted REQ drop aborts
// STROBE  | SAMPLE high for one cycle, load hold count
// HOLD    | keep select stable while the sample is taken
// RELEASE | DONE high, grant and enable already cleared, advance pointer
module lt1364_mux_sequencer
  import lt1364_seq_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int SEL_W      = 2,
  parameter int SETTLE_CYC = 8,
  parameter int HOLD_CYC   = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  lt1364_mux_sequencer_if.slave io_bus
);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_gidx;
  logic             r_ch;
  logic [NREQ-1:0]  r_gnt;
  logic [SEL_W-1:0] r_mux1_sel;
  logic [SEL_W-1:0] r_mux2_sel;
  logic             r_mux1_en;
  logic             r_mux2_en;
  logic             r_sample;
  logic             r_done;
  logic             r_abort;

  logic [NREQ-1:0]  w_arb_gnt;
  logic [SEL_W-1:0] w_arb_idx;
  logic             w_arb_valid;
  logic             w_req_held;
  logic             w_blank;

  rr_arbiter #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_arb (
    .i_req   (io_bus.req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_req_held = io_bus.req[r_gidx];

`ifdef LT1364_SEQ_BLANK_EN
  assign w_blank = (r_state == ST_SWITCH) || (r_state == ST_SETTLE) || (r_state == ST_STROBE);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_ch       <= CH1;
      r_gnt      <= '0;
      r_mux1_sel <= '0;
      r_mux2_sel <= '0;
      r_mux1_en  <= 1'b0;
      r_mux2_en  <= 1'b0;
      r_sample   <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_gnt  <= w_arb_gnt;
            r_gidx <= w_arb_idx;
            r_ch   <= io_bus.req_ch[w_arb_idx];
            if (io_bus.req_ch[w_arb_idx] == CH1) r_mux1_sel <= w_arb_idx;
            else                                 r_mux2_sel <= w_arb_idx;
            r_state <= ST_SWITCH;
          end
        end
        ST_SWITCH, ST_SETTLE: begin
          if (!w_req_held) begin
            r_abort   <= 1'b1;
            r_gnt     <= '0;
            r_mux1_en <= 1'b0;
            r_mux2_en <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (r_state == ST_SWITCH) begin
            if (r_ch == CH1) r_mux1_en <= 1'b1;
            else             r_mux2_en <= 1'b1;
            r_cnt   <= CNT_W'(SETTLE_CYC - 1);
            r_state <= ST_SETTLE;
          end else if (r_cnt == '0) begin
            r_sample <= 1'b1;
            r_state  <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          r_cnt   <= CNT_W'(HOLD_CYC - 1);
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_done    <= 1'b1;
            r_gnt     <= '0;
            r_mux1_en <= 1'b0;
            r_mux2_en <= 1'b0;
            r_ptr     <= SEL_W'(rr_next(int'(r_gidx), NREQ));
            r_state   <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
      // Blanking only ever clears the channel that is not carrying this conversion.
      if (w_blank) begin
        if (r_ch == CH1) r_mux2_en <= 1'b0;
        else             r_mux1_en <= 1'b0;
      end
    end
  end

  assign io_bus.gnt      = r_gnt;
  assign io_bus.mux1_sel = r_mux1_sel;
  assign io_bus.mux1_en  = r_mux1_en;
  assign io_bus.mux2_sel = r_mux2_sel;
  assign io_bus.mux2_en  = r_mux2_en;
  assign io_bus.sample   = r_sample;
  assign io_bus.done     = r_done;
  assign io_bus.abort    = r_abort;
  assign io_bus.busy     = (r_state != ST_IDLE);

endmodule
